amns_mm_sched: RTL and testbench

Operation scheduler that sits in front of the AMNS polynomial FIOS multiplier array (N coefficients × S word-lines). It accepts tagged multiplication requests over a valid/ready handshake and streams the N B/M operand words from operand memory. It then issues staggered per-line start pulses with run-time-selectable active line count and compile-time line spacing, and returns completion tags in order. It generalises the fixed start[0]-only, fixed-delay, single-operation control to pipelined multi-operation scheduling with backpressure.

---
 rtl/amns_mm_pkg.sv | 27 ++
 rtl/tag_fifo.sv | 56 +++++
 rtl/amns_mm_sched.sv | 162 ++++++++++++++++
 tb/tb_amns_mm_sched.sv | 261 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/amns_mm_pkg.sv
// Shared types, defaults and width helpers for the AMNS multiplier scheduler.
package amns_mm_pkg;

    typedef enum logic [1:0] {
        IDLE,
        LOAD,
        WAIT_MEM,
        RUN
    } sched_state_t;

    localparam int DEF_N            = 5;
    localparam int DEF_S            = 4;
    localparam int DEF_MEM_LAT      = 1;
    localparam int DEF_TAG_WIDTH    = 4;
    localparam int DEF_MAX_INFLIGHT = 2;

    // Each line of the FIOS array needs 4N+2 cycles before the next line can start.
    function automatic int line_spacing(input int n);
        return 4 * n + 2;
    endfunction

    // Bits needed to hold values 0..max_val, never less than one bit.
    function automatic int cnt_w(input int max_val);
        return (max_val < 2) ? 1 : $clog2(max_val + 1);
    endfunction

endpackage

// File: rtl/tag_fifo.sv
// Synchronous tag FIFO holding the tags of accepted, not yet answered operations.
module tag_fifo #(
    parameter int WIDTH = 4,
    parameter int DEPTH = 2
) (
    input  logic                       i_clk,
    input  logic                       i_rst_n,
    input  logic                       i_push,
    input  logic                       i_pop,
    input  logic [WIDTH-1:0]           i_data,
    output logic [WIDTH-1:0]           o_data,
    output logic                       o_full,
    output logic                       o_empty,
    output logic [$clog2(DEPTH+1)-1:0] o_count
);

    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [PW-1:0]    r_wr;
    logic [PW-1:0]    r_rd;
    logic [CW-1:0]    r_count;
    logic             w_push;
    logic             w_pop;

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    assign w_push  = i_push && (r_count != CW'(DEPTH));
    assign w_pop   = i_pop && (r_count != '0);
    assign o_data  = r_mem[r_rd];
    assign o_full  = (r_count == CW'(DEPTH));
    assign o_empty = (r_count == '0);
    assign o_count = r_count;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_wr    <= '0;
            r_rd    <= '0;
            r_count <= '0;
        end else begin
            if (w_push) r_wr <= ptr_inc(r_wr);
            if (w_pop)  r_rd <= ptr_inc(r_rd);
            if (w_push && !w_pop)      r_count <= r_count + 1'b1;
            else if (w_pop && !w_push) r_count <= r_count - 1'b1;
        end
    end

    // Tag storage is plain data; pointers alone define validity.
    always_ff @(posedge i_clk) begin
        if (w_push) r_mem[r_wr] <= i_data;
    end

endmodule

// File: rtl/amns_mm_sched.sv
// Scheduler for the AMNS FIOS multiplier array: streams operands, staggers line
// starts and returns completion tags in issue order.
module amns_mm_sched
    import amns_mm_pkg::*;
#(
    parameter int N            = DEF_N,
    parameter int S            = DEF_S,
    parameter int LINE_SPACING = line_spacing(DEF_N),
    parameter int MEM_LAT      = DEF_MEM_LAT,
    parameter int TAG_WIDTH    = DEF_TAG_WIDTH,
    parameter int MAX_INFLIGHT = DEF_MAX_INFLIGHT
) (
    input  logic                    clock_i,
    input  logic                    reset_i,
    input  logic                    req_valid_i,
    output logic                    req_ready_o,
    input  logic [TAG_WIDTH-1:0]    req_tag_i,
    input  logic [cnt_w(S)-1:0]     req_lines_i,
    output logic                    mem_rd_en_o,
    output logic [cnt_w(N-1)-1:0]   mem_addr_o,
    output logic [S-1:0]            line_start_o,
    input  logic                    array_done_i,
    output logic                    rsp_valid_o,
    input  logic                    rsp_ready_i,
    output logic [TAG_WIDTH-1:0]    rsp_tag_o,
    output logic                    busy_o,
    output logic                    err_o
);

    localparam int AW  = cnt_w(N - 1);
    localparam int LW  = cnt_w(S);
    localparam int SPW = cnt_w(LINE_SPACING);
    localparam int MLW = cnt_w(MEM_LAT);
    localparam int PW  = cnt_w(MAX_INFLIGHT);

    sched_state_t     r_state;
    sched_state_t     w_state_nxt;
    logic             r_live;
    logic [AW-1:0]    r_addr;
    logic [MLW-1:0]   r_wait;
    logic [SPW-1:0]   r_spc;
    logic [LW-1:0]    r_line;
    logic [LW-1:0]    r_lines;
    logic [PW-1:0]    r_pend;
    logic             r_err;

    logic             w_req_hs;
    logic             w_lines_bad;
    logic [LW-1:0]    w_lines_eff;
    logic             w_last_pulse;
    logic             w_rsp_valid;
    logic             w_pop;
    logic             w_done_bad;
    logic             w_done_ok;
    logic             w_fifo_full;
    logic             w_fifo_empty;
    logic [PW-1:0]    w_fifo_count;
    logic [TAG_WIDTH-1:0] w_head;

    // Out-of-range line counts fall back to the full array width.
    assign w_lines_bad  = (req_lines_i == '0) || (req_lines_i > LW'(S));
    assign w_lines_eff  = w_lines_bad ? LW'(S) : req_lines_i;
    assign req_ready_o  = (r_state == IDLE) && r_live && !w_fifo_full;
    assign w_req_hs     = req_valid_i && req_ready_o;
    assign w_last_pulse = (r_spc == '0) && (r_line == r_lines - LW'(1));

    assign w_rsp_valid  = (r_pend != '0);
    assign w_pop        = w_rsp_valid && rsp_ready_i;
    assign w_done_bad   = array_done_i && (r_pend == w_fifo_count);
    assign w_done_ok    = array_done_i && !w_done_bad;

    assign rsp_valid_o  = w_rsp_valid;
    assign rsp_tag_o    = w_rsp_valid ? w_head : '0;
    assign busy_o       = (r_state != IDLE) || !w_fifo_empty;
    assign err_o        = r_err;

    tag_fifo #(
        .WIDTH (TAG_WIDTH),
        .DEPTH (MAX_INFLIGHT)
    ) u_tag_fifo (
        .i_clk   (clock_i),
        .i_rst_n (reset_i),
        .i_push  (w_req_hs),
        .i_pop   (w_pop),
        .i_data  (req_tag_i),
        .o_data  (w_head),
        .o_full  (w_fifo_full),
        .o_empty (w_fifo_empty),
        .o_count (w_fifo_count)
    );

    always_ff @(posedge clock_i or negedge reset_i) begin
        if (!reset_i) begin
            r_state <= IDLE;
            r_live  <= 1'b0;
            r_addr  <= '0;
            r_wait  <= '0;
            r_spc   <= '0;
            r_line  <= '0;
            r_lines <= '0;
            r_pend  <= '0;
            r_err   <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_live  <= 1'b1;

            if (w_req_hs) begin
                r_lines <= w_lines_eff;
                r_addr  <= '0;
            end else if (r_state == LOAD) begin
                r_addr  <= r_addr + 1'b1;
            end

            if (r_state == WAIT_MEM) r_wait <= r_wait + 1'b1;
            else                     r_wait <= '0;

            // Spacing counter reloads on every pulse and idles at zero outside RUN.
            if (r_state == RUN) begin
                if (r_spc == '0) begin
                    r_line <= r_line + 1'b1;
                    r_spc  <= SPW'(LINE_SPACING - 1);
                end else begin
                    r_spc  <= r_spc - 1'b1;
                end
            end else begin
                r_line <= '0;
                r_spc  <= '0;
            end

            if (w_done_ok && !w_pop)      r_pend <= r_pend + 1'b1;
            else if (w_pop && !w_done_ok) r_pend <= r_pend - 1'b1;

            if ((w_req_hs && w_lines_bad) || w_done_bad) r_err <= 1'b1;
        end
    end

    always_comb begin
        w_state_nxt  = r_state;
        mem_rd_en_o  = 1'b0;
        mem_addr_o   = '0;
        line_start_o = '0;
        unique case (r_state)
            IDLE: begin
                if (w_req_hs) w_state_nxt = LOAD;
            end
            LOAD: begin
                mem_rd_en_o = 1'b1;
                mem_addr_o  = r_addr;
                if (r_addr == AW'(N - 1)) w_state_nxt = (MEM_LAT > 1) ? WAIT_MEM : RUN;
            end
            WAIT_MEM: begin
                if (r_wait == MLW'(MEM_LAT - 2)) w_state_nxt = RUN;
            end
            RUN: begin
                if (r_spc == '0) line_start_o = S'(1) << r_line;
                if (w_last_pulse) w_state_nxt = IDLE;
            end
            default: w_state_nxt = IDLE;
        endcase
    end

endmodule

// File: tb/tb_amns_mm_sched.sv
// Self-checking bench for amns_mm_sched: table-driven operations plus hand-written
// backpressure, inflight-limit, error and reset sequences, with a tag scoreboard.
module tb_amns_mm_sched;

    localparam int N  = 5;
    localparam int S  = 4;
    localparam int LS = 22;
    localparam int ML = 1;
    localparam int TW = 4;
    localparam int MI = 2;

    logic          clock_i = 1'b0;
    logic          reset_i = 1'b0;
    logic          req_valid_i = 1'b0;
    logic          req_ready_o;
    logic [TW-1:0] req_tag_i = '0;
    logic [2:0]    req_lines_i = '0;
    logic          mem_rd_en_o;
    logic [2:0]    mem_addr_o;
    logic [S-1:0]  line_start_o;
    logic          array_done_i = 1'b0;
    logic          rsp_valid_o;
    logic          rsp_ready_i = 1'b0;
    logic [TW-1:0] rsp_tag_o;
    logic          busy_o;
    logic          err_o;

    int n_cmp = 0;
    int n_bad = 0;
    logic [TW-1:0] q[$];

    typedef struct {
        logic [TW-1:0] tag;
        logic [2:0]    lines;
        int            exp_lines;
        int            exp_err;
    } vec_t;

    vec_t vecs[6];

    amns_mm_sched #(
        .N(N), .S(S), .LINE_SPACING(LS), .MEM_LAT(ML), .TAG_WIDTH(TW), .MAX_INFLIGHT(MI)
    ) dut (
        .clock_i      (clock_i),
        .reset_i      (reset_i),
        .req_valid_i  (req_valid_i),
        .req_ready_o  (req_ready_o),
        .req_tag_i    (req_tag_i),
        .req_lines_i  (req_lines_i),
        .mem_rd_en_o  (mem_rd_en_o),
        .mem_addr_o   (mem_addr_o),
        .line_start_o (line_start_o),
        .array_done_i (array_done_i),
        .rsp_valid_o  (rsp_valid_o),
        .rsp_ready_i  (rsp_ready_i),
        .rsp_tag_o    (rsp_tag_o),
        .busy_o       (busy_o),
        .err_o        (err_o)
    );

    always #5 clock_i = ~clock_i;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tick;
        @(posedge clock_i);
        #1;
    endtask

    task automatic chk(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic chk_all_zero(input string name);
        chk({name, "_req_ready"}, req_ready_o, 0);
        chk({name, "_rd_en"}, mem_rd_en_o, 0);
        chk({name, "_addr"}, mem_addr_o, 0);
        chk({name, "_starts"}, line_start_o, 0);
        chk({name, "_rsp_valid"}, rsp_valid_o, 0);
        chk({name, "_rsp_tag"}, rsp_tag_o, 0);
        chk({name, "_busy"}, busy_o, 0);
        chk({name, "_err"}, err_o, 0);
    endtask

    // Issue one request and follow it until the cycle after its last start pulse.
    task automatic run_op(input logic [TW-1:0] tag, input logic [2:0] lines, input int exp_lines);
        int pulse[S];
        int rdy_at, bad_addr, multi, last_t, end_t, exp_rdy;
        for (int j = 0; j < S; j++) pulse[j] = -1;
        rdy_at = -1; bad_addr = 0; multi = 0;
        last_t = N + ML + (exp_lines - 1) * LS;
        end_t  = last_t + 1;
        chk("op_ready_before", req_ready_o, 1);
        req_valid_i = 1'b1; req_tag_i = tag; req_lines_i = lines;
        tick;
        req_valid_i = 1'b0;
        q.push_back(tag);
        exp_rdy = (q.size() < MI) ? end_t : -1;
        for (int t = 1; t <= end_t; t++) begin
            if (mem_rd_en_o !== (t <= N)) bad_addr++;
            else if (mem_rd_en_o && (int'(mem_addr_o) != t - 1)) bad_addr++;
            if ($countones(line_start_o) > 1) multi++;
            for (int j = 0; j < S; j++) begin
                if (line_start_o[j]) begin
                    if (pulse[j] < 0) pulse[j] = t;
                    else multi++;
                end
            end
            if (req_ready_o && rdy_at < 0) rdy_at = t;
            if (t < end_t) tick;
        end
        for (int j = 0; j < S; j++)
            chk($sformatf("op_tag%0d_pulse%0d_cycle", tag, j), pulse[j],
                (j < exp_lines) ? (N + ML + j * LS) : -1);
        chk($sformatf("op_tag%0d_ready_cycle", tag), rdy_at, exp_rdy);
        chk($sformatf("op_tag%0d_mem_stream", tag), bad_addr, 0);
        chk($sformatf("op_tag%0d_onehot", tag), multi, 0);
    endtask

    task automatic done_pulse;
        array_done_i = 1'b1;
        tick;
        array_done_i = 1'b0;
    endtask

    task automatic complete_one(input string name);
        done_pulse;
        chk({name, "_rsp_valid"}, rsp_valid_o, 1);
        chk({name, "_rsp_tag"}, rsp_tag_o, q[0]);
        rsp_ready_i = 1'b1;
        tick;
        rsp_ready_i = 1'b0;
        void'(q.pop_front());
        chk({name, "_rsp_after_pop"}, rsp_valid_o, 0);
    endtask

    initial begin
        int seen;
        int bad_cnt;

        vecs[0] = '{tag: 4'd3,  lines: 3'd4, exp_lines: 4, exp_err: 0};
        vecs[1] = '{tag: 4'd7,  lines: 3'd2, exp_lines: 2, exp_err: 0};
        vecs[2] = '{tag: 4'd5,  lines: 3'd1, exp_lines: 1, exp_err: 0};
        vecs[3] = '{tag: 4'd9,  lines: 3'd3, exp_lines: 3, exp_err: 0};
        vecs[4] = '{tag: 4'd10, lines: 3'd0, exp_lines: 4, exp_err: 1};
        vecs[5] = '{tag: 4'd11, lines: 3'd5, exp_lines: 4, exp_err: 1};

        // Reset state
        tick; tick;
        chk_all_zero("in_reset");
        reset_i = 1'b1;
        tick;
        chk("ready_after_release", req_ready_o, 1);
        chk("busy_after_release", busy_o, 0);

        // Inflight limit and response backpressure
        run_op(4'd1, 3'd1, 1);
        run_op(4'd2, 3'd1, 1);
        req_valid_i = 1'b1; req_tag_i = 4'd4; req_lines_i = 3'd1;
        bad_cnt = 0;
        for (int i = 0; i < 3; i++) begin
            if (req_ready_o || mem_rd_en_o) bad_cnt++;
            tick;
        end
        req_valid_i = 1'b0;
        chk("full_blocks_request", bad_cnt, 0);
        chk("full_busy", busy_o, 1);
        done_pulse;
        chk("bp_tag_a", rsp_tag_o, q[0]);
        tick;
        done_pulse;
        chk("bp_valid", rsp_valid_o, 1);
        chk("bp_tag_b", rsp_tag_o, q[0]);
        tick;
        chk("bp_tag_c", rsp_tag_o, q[0]);
        rsp_ready_i = 1'b1;
        tick;
        void'(q.pop_front());
        chk("ready_after_pop", req_ready_o, 1);
        chk("second_rsp_valid", rsp_valid_o, 1);
        chk("second_rsp_tag", rsp_tag_o, q[0]);
        tick;
        void'(q.pop_front());
        rsp_ready_i = 1'b0;
        chk("drained_rsp_valid", rsp_valid_o, 0);
        chk("drained_busy", busy_o, 0);

        // Simultaneous push and pop
        run_op(4'd6, 3'd1, 1);
        done_pulse;
        chk("pp_rsp_tag", rsp_tag_o, q[0]);
        void'(q.pop_front());
        rsp_ready_i = 1'b1;
        run_op(4'd8, 3'd1, 1);
        rsp_ready_i = 1'b0;
        complete_one("pp_second");
        chk("pp_busy", busy_o, 0);
        chk("pp_err", err_o, 0);
        chk("pp_ready", req_ready_o, 1);

        // Table of single operations
        for (int v = 0; v < 6; v++) begin
            run_op(vecs[v].tag, vecs[v].lines, vecs[v].exp_lines);
            chk($sformatf("vec%0d_err", v), err_o, vecs[v].exp_err);
            complete_one($sformatf("vec%0d", v));
        end

        // Spurious completion after reset
        reset_i = 1'b0;
        #2;
        reset_i = 1'b1;
        q.delete();
        tick;
        chk("sp_err_before", err_o, 0);
        done_pulse;
        chk("sp_err", err_o, 1);
        chk("sp_rsp_valid", rsp_valid_o, 0);
        tick;
        chk("sp_rsp_valid_later", rsp_valid_o, 0);

        // Asynchronous reset in the middle of RUN
        req_valid_i = 1'b1; req_tag_i = 4'd12; req_lines_i = 3'd4;
        tick;
        req_valid_i = 1'b0;
        seen = 0;
        for (int t = 1; t < 200 && seen == 0; t++) begin
            if (line_start_o[1]) seen = 1;
            else tick;
        end
        chk("mid_pulse1_seen", seen, 1);
        for (int i = 0; i < 5; i++) tick;
        chk("mid_busy_before", busy_o, 1);
        #2;
        reset_i = 1'b0;
        #1;
        chk_all_zero("mid_reset");
        q.delete();
        tick; tick;
        reset_i = 1'b1;
        bad_cnt = 0;
        for (int i = 0; i < 100; i++) begin
            tick;
            if (line_start_o != '0 || rsp_valid_o || mem_rd_en_o || busy_o) bad_cnt++;
        end
        chk("after_reset_quiet", bad_cnt, 0);
        chk("after_reset_ready", req_ready_o, 1);
        chk("after_reset_err", err_o, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
